// File: rtl/bcd_tens_display.sv
// Tens stage for a single-digit up/down BCD counter: wrap detection, tens digit,
// and a two-digit time-multiplexed 7-segment driver.
module bcd_tens_display #(
   parameter int SCAN_DIV       = 4,
   parameter bit LZB            = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   output logic [3:0] tens,
   output logic       ovf,
   output logic       unf,
   output logic       err,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
   localparam logic [1:0]    AN_OFF    = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

   logic [3:0]    units;
   logic [3:0]    prev;
   logic          prev_valid;
   logic          units_ok;
   logic          prev_ok;
   logic          up_wrap;
   logic          down_wrap;
   logic [CW-1:0] scan_cnt;
   logic          sel;
   logic [6:0]    disp_seg;
   logic [1:0]    disp_an;

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'b0111111;
         4'd1:    enc = 7'b0000110;
         4'd2:    enc = 7'b1011011;
         4'd3:    enc = 7'b1001111;
         4'd4:    enc = 7'b1100110;
         4'd5:    enc = 7'b1101101;
         4'd6:    enc = 7'b1111101;
         4'd7:    enc = 7'b0000111;
         4'd8:    enc = 7'b1111111;
         4'd9:    enc = 7'b1101111;
         default: enc = 7'b1000000;
      endcase
   endfunction

   assign units     = {A, B, C, D};
   assign units_ok  = (units <= 4'd9);
   assign prev_ok   = (prev <= 4'd9);
   // Direction comes purely from the 9<->0 transition; an invalid code in between disarms it.
   assign up_wrap   = prev_valid && units_ok && (prev == 4'd9) && (units == 4'd0);
   assign down_wrap = prev_valid && units_ok && (prev == 4'd0) && (units == 4'd9);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev       <= 4'd0;
         prev_valid <= 1'b0;
         tens       <= 4'd0;
         ovf        <= 1'b0;
         unf        <= 1'b0;
         err        <= 1'b0;
      end else begin
         prev       <= units;
         prev_valid <= units_ok;
         ovf        <= 1'b0;
         unf        <= 1'b0;
         if (!units_ok) begin
            err <= 1'b1;
         end
         if (up_wrap) begin
            if (tens == 4'd9) begin
               tens <= 4'd0;
               ovf  <= 1'b1;
            end else begin
               tens <= tens + 4'd1;
            end
         end else if (down_wrap) begin
            if (tens == 4'd0) begin
               tens <= 4'd9;
               unf  <= 1'b1;
            end else begin
               tens <= tens - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt <= '0;
         sel      <= 1'b0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         sel      <= ~sel;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Units slot shows the registered sample, so the display trails the input by one edge.
   always_comb begin
      disp_seg = 7'b0000000;
      disp_an  = 2'b01;
      if (!sel) begin
         disp_an  = 2'b01;
         disp_seg = prev_ok ? enc(prev) : 7'b1000000;
      end else begin
         disp_an  = 2'b10;
         disp_seg = (LZB && (tens == 4'd0)) ? 7'b0000000 : enc(tens);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= SEG_ACTIVE_LOW ? ~disp_seg : disp_seg;
         an  <= SEG_ACTIVE_LOW ? ~disp_an : disp_an;
      end
   end

endmodule
